// File: rtl/asym_fifo_pkg.sv
// Shared helpers for the asymmetric-width FIFO:
// log2/min/max and width-ratio derivation.
package asym_fifo_pkg;

  function automatic int log2(input int v);
    int r;
    r = 0;
    for (int k = 0; k < 31; k++)
      if ((1 << k) < v) r = k + 1;
    return r;
  endfunction

  function automatic int maxOf(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int minOf(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic bit isPow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

  function automatic int unitsOf(input int w, input int ww,
                                 input int wr);
    return w / minOf(ww, wr);
  endfunction

  function automatic bit cfgOk(input int ww, input int wr,
                               input int d);
    int mn;
    int mx;
    mn = minOf(ww, wr);
    mx = maxOf(ww, wr);
    return (mn > 0) && (mx % mn == 0) && isPow2(mx / mn)
        && isPow2(d)
        && (d >= 2 * maxOf(ww / mn, wr / mn));
  endfunction

endpackage

// File: rtl/asym_width_fifo_if.sv
// Write/read bundle of the asymmetric-width FIFO.
// master = producer/consumer side, slave = FIFO side.
interface asym_width_fifo_if
  import asym_fifo_pkg::*;
#(
  parameter int WIDTHW = 32,
  parameter int WIDTHR = 8,
  parameter int DEPTH  = 256
);
  localparam int LW = log2(DEPTH) + 1;

  logic              wr_en;
  logic [WIDTHW-1:0] wr_data;
  logic              full;
  logic              wr_overflow;
  logic              rd_en;
  logic [WIDTHR-1:0] rd_data;
  logic              rd_valid;
  logic              empty;
  logic              rd_underflow;
  logic [LW-1:0]     level;

  modport master (
    output wr_en, wr_data, rd_en,
    input  full, wr_overflow, rd_data,
    input  rd_valid, empty, rd_underflow, level
  );

  modport slave (
    input  wr_en, wr_data, rd_en,
    output full, wr_overflow, rd_data,
    output rd_valid, empty, rd_underflow, level
  );
endinterface

// File: rtl/asym_fifo_mem.sv
// Unit-granular storage: one WIDTHW write port,
// one registered WIDTHR read port, little-endian units.
module asym_fifo_mem
  import asym_fifo_pkg::*;
#(
  parameter int WIDTHW = 32,
  parameter int WIDTHR = 8,
  parameter int DEPTH  = 256,
  localparam int AW    = log2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wrEn,
  input  logic [AW-1:0]     wrAddr,
  input  logic [WIDTHW-1:0] wrData,
  input  logic              rdEn,
  input  logic [AW-1:0]     rdAddr,
  output logic [WIDTHR-1:0] rdData
);
  localparam int MINW = minOf(WIDTHW, WIDTHR);
  localparam int WU   = unitsOf(WIDTHW, WIDTHW, WIDTHR);
  localparam int RU   = unitsOf(WIDTHR, WIDTHW, WIDTHR);

  logic [MINW-1:0] mem [DEPTH];
  logic [AW-1:0]   wIdx [WU];
  logic [MINW-1:0] wUnit [WU];

  for (genvar i = 0; i < WU; i++) begin : gWr
    assign wIdx[i]  = wrAddr + AW'(i);
    assign wUnit[i] = wrData[i*MINW +: MINW];
  end

  always_ff @(posedge clk) begin
    if (wrEn)
      for (int i = 0; i < WU; i++)
        mem[wIdx[i]] <= wUnit[i];
  end

  for (genvar j = 0; j < RU; j++) begin : gRd
    logic [AW-1:0]   rIdx;
    logic [MINW-1:0] q;
    assign rIdx = rdAddr + AW'(j);
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    q <= '0;
      else if (rdEn) q <= mem[rIdx];
    end
    assign rdData[j*MINW +: MINW] = q;
  end
endmodule

// File: rtl/asym_width_fifo.sv
// Asymmetric-width FIFO: pointers, level and flags;
// storage lives in asym_fifo_mem.
module asym_width_fifo
  import asym_fifo_pkg::*;
#(
  parameter int WIDTHW = 32,
  parameter int WIDTHR = 8,
  parameter int DEPTH  = 256
) (
  input  logic clk,
  input  logic rst_n,
  asym_width_fifo_if.slave bus
);
  localparam int WU = unitsOf(WIDTHW, WIDTHW, WIDTHR);
  localparam int RU = unitsOf(WIDTHR, WIDTHW, WIDTHR);
  localparam int AW = log2(DEPTH);
  localparam int PW = AW + 1;

  localparam logic [PW-1:0] WSTEP = PW'(WU);
  localparam logic [PW-1:0] RSTEP = PW'(RU);
  localparam logic [PW-1:0] CAP   = PW'(DEPTH);

  if (!cfgOk(WIDTHW, WIDTHR, DEPTH)) begin : gBadCfg
    $error("asym_width_fifo: bad width ratio or DEPTH");
  end

  logic [PW-1:0]     wPtr;
  logic [PW-1:0]     rPtr;
  logic [PW-1:0]     lvl;
  logic              isFull;
  logic              isEmpty;
  logic              wrAcc;
  logic              rdAcc;
  logic              rdValid;
  logic              wrOvf;
  logic              rdUnf;
  logic [WIDTHR-1:0] rdData;

  // wrap bit makes the difference the true occupancy
  assign lvl     = wPtr - rPtr;
  assign isFull  = (CAP - lvl) < WSTEP;
  assign isEmpty = lvl < RSTEP;
  assign wrAcc   = bus.wr_en & ~isFull;
  assign rdAcc   = bus.rd_en & ~isEmpty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wPtr    <= '0;
      rPtr    <= '0;
      rdValid <= 1'b0;
      wrOvf   <= 1'b0;
      rdUnf   <= 1'b0;
    end else begin
      if (wrAcc) wPtr <= wPtr + WSTEP;
      if (rdAcc) rPtr <= rPtr + RSTEP;
      rdValid <= rdAcc;
      wrOvf   <= bus.wr_en & isFull;
      rdUnf   <= bus.rd_en & isEmpty;
    end
  end

  asym_fifo_mem #(
    .WIDTHW(WIDTHW),
    .WIDTHR(WIDTHR),
    .DEPTH (DEPTH)
  ) uMem (
    .clk   (clk),
    .rst_n (rst_n),
    .wrEn  (wrAcc),
    .wrAddr(wPtr[AW-1:0]),
    .wrData(bus.wr_data),
    .rdEn  (rdAcc),
    .rdAddr(rPtr[AW-1:0]),
    .rdData(rdData)
  );

  assign bus.full         = isFull;
  assign bus.empty        = isEmpty;
  assign bus.level        = lvl;
  assign bus.rd_valid     = rdValid;
  assign bus.rd_data      = rdData;
  assign bus.wr_overflow  = wrOvf;
  assign bus.rd_underflow = rdUnf;
endmodule

// File: tb/tb_asym_width_fifo.sv
// Directed bench: 32->8 and 8->32 FIFOs, DEPTH 16.
// Inputs change and outputs sample 1ns after posedge.
module tb_asym_width_fifo;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  asym_width_fifo_if #(
    .WIDTHW(32), .WIDTHR(8), .DEPTH(16)) a();
  asym_width_fifo_if #(
    .WIDTHW(8), .WIDTHR(32), .DEPTH(16)) b();

  asym_width_fifo #(
    .WIDTHW(32), .WIDTHR(8), .DEPTH(16)
  ) dutA (.clk(clk), .rst_n(rst_n), .bus(a.slave));

  asym_width_fifo #(
    .WIDTHW(8), .WIDTHR(32), .DEPTH(16)
  ) dutB (.clk(clk), .rst_n(rst_n), .bus(b.slave));

  int nChecks = 0;
  int nErrors = 0;
  logic [7:0] q[$];

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // one cycle on port A against the byte-queue model
  task automatic stepA(input bit w, input logic [31:0] d,
                       input bit r);
    bit wOk;
    bit rOk;
    logic [7:0] e;
    int n;
    e = '0;
    n = q.size();
    wOk = w && ((16 - n) >= 4);
    rOk = r && (n >= 1);
    a.wr_en = w;
    a.wr_data = d;
    a.rd_en = r;
    if (rOk) e = q.pop_front();
    if (wOk)
      for (int j = 0; j < 4; j++) q.push_back(d[8*j +: 8]);
    tick();
    a.wr_en = 1'b0;
    a.rd_en = 1'b0;
    n = q.size();
    chk("s_level", 32'(a.level), 32'(n));
    chk("s_valid", 32'(a.rd_valid), 32'(rOk));
    if (rOk) chk("s_data", 32'(a.rd_data), 32'(e));
    chk("s_full", 32'(a.full), 32'((16 - n) < 4));
    chk("s_empty", 32'(a.empty), 32'(n < 1));
    chk("s_ovf", 32'(a.wr_overflow), 32'(w && !wOk));
    chk("s_unf", 32'(a.rd_underflow), 32'(r && !rOk));
  endtask

  logic [7:0]  e034 [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  logic [31:0] w035 [4] = '{32'hA3A2A1A0, 32'hB3B2B1B0,
                            32'hC3C2C1C0, 32'hD3D2D1D0};
  logic [7:0]  e039 [4] = '{8'h55, 8'h66, 8'h77, 8'h88};

  initial begin
    logic [7:0] nb;
    a.wr_en = 0; a.rd_en = 0; a.wr_data = '0;
    b.wr_en = 0; b.rd_en = 0; b.wr_data = '0;

    rst_n = 1'b0;
    tick(); tick();
    chk("rst_level", 32'(a.level), 0);
    chk("rst_empty", 32'(a.empty), 1);
    chk("rst_full", 32'(a.full), 0);
    chk("rst_valid", 32'(a.rd_valid), 0);
    chk("rst_data", 32'(a.rd_data), 0);
    chk("rst_ovf", 32'(a.wr_overflow), 0);
    chk("rst_unf", 32'(a.rd_underflow), 0);
    chk("rst_b_empty", 32'(b.empty), 1);
    chk("rst_b_data", b.rd_data, 0);
    rst_n = 1'b1;
    tick();

    // one word out as four bytes, LSB first
    a.wr_en = 1; a.wr_data = 32'h44332211;
    tick();
    a.wr_en = 0;
    chk("w1_level", 32'(a.level), 4);
    chk("w1_empty", 32'(a.empty), 0);
    a.rd_en = 1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("r1_valid", 32'(a.rd_valid), 1);
      chk("r1_data", 32'(a.rd_data), 32'(e034[k]));
    end
    a.rd_en = 0;
    chk("r1_empty", 32'(a.empty), 1);
    tick();
    chk("r1_idle_valid", 32'(a.rd_valid), 0);
    chk("r1_hold", 32'(a.rd_data), 32'h44);

    // underflow
    a.rd_en = 1;
    tick();
    a.rd_en = 0;
    chk("unf_pulse", 32'(a.rd_underflow), 1);
    chk("unf_valid", 32'(a.rd_valid), 0);
    chk("unf_level", 32'(a.level), 0);
    tick();
    chk("unf_clear", 32'(a.rd_underflow), 0);

    // fill, overflow, drain across wrap
    for (int k = 0; k < 4; k++) begin
      a.wr_en = 1; a.wr_data = w035[k];
      tick();
    end
    chk("fill_level", 32'(a.level), 16);
    chk("fill_full", 32'(a.full), 1);
    a.wr_data = 32'hDEADBEEF;
    tick();
    a.wr_en = 0;
    chk("ovf_pulse", 32'(a.wr_overflow), 1);
    chk("ovf_level", 32'(a.level), 16);
    tick();
    chk("ovf_clear", 32'(a.wr_overflow), 0);
    a.rd_en = 1;
    for (int k = 0; k < 4; k++)
      for (int j = 0; j < 4; j++) begin
        tick();
        chk("drain_data", 32'(a.rd_data),
            32'(w035[k][8*j +: 8]));
      end
    a.rd_en = 0;
    chk("drain_empty", 32'(a.empty), 1);
    chk("drain_full", 32'(a.full), 0);

    // simultaneous read+write at level 8
    a.wr_en = 1; a.wr_data = 32'h03020100;
    tick();
    a.wr_data = 32'h07060504;
    tick();
    chk("l8_level", 32'(a.level), 8);
    a.wr_data = 32'h0B0A0908; a.rd_en = 1;
    tick();
    a.wr_en = 0; a.rd_en = 0;
    chk("rw_level", 32'(a.level), 11);
    chk("rw_valid", 32'(a.rd_valid), 1);
    chk("rw_data", 32'(a.rd_data), 32'h00);
    q.delete();
    for (int k = 1; k < 12; k++) q.push_back(8'(k));
    nb = 8'h0C;
    for (int i = 0; i < 20; i++) begin
      stepA(i % 4 == 0, {nb + 8'd3, nb + 8'd2,
                         nb + 8'd1, nb}, 1'b1);
      if (i % 4 == 0) nb = nb + 8'd4;
    end
    for (int i = 0; i < 16 && q.size() > 0; i++)
      stepA(1'b0, '0, 1'b1);
    stepA(1'b0, '0, 1'b1);

    // reset mid-stream at level 12
    a.wr_en = 1; a.wr_data = 32'h13121110;
    tick();
    a.wr_data = 32'h17161514;
    tick();
    a.wr_data = 32'h1B1A1918;
    tick();
    a.wr_en = 0;
    chk("pre_rst_level", 32'(a.level), 12);
    a.rd_en = 1;
    tick();
    chk("pre_rst_valid", 32'(a.rd_valid), 1);
    chk("pre_rst_data", 32'(a.rd_data), 32'h10);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_level", 32'(a.level), 0);
    chk("mid_rst_empty", 32'(a.empty), 1);
    chk("mid_rst_valid", 32'(a.rd_valid), 0);
    chk("mid_rst_data", 32'(a.rd_data), 0);
    a.rd_en = 0;
    tick();
    rst_n = 1'b1;
    tick();
    a.wr_en = 1; a.wr_data = 32'h88776655;
    tick();
    a.wr_en = 0; a.rd_en = 1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("post_rst_data", 32'(a.rd_data), 32'(e039[k]));
    end
    a.rd_en = 0;
    chk("post_rst_empty", 32'(a.empty), 1);

    // narrow write, wide read
    b.wr_en = 1; b.wr_data = 8'hAA;
    tick();
    b.wr_data = 8'hBB;
    tick();
    b.wr_data = 8'hCC;
    tick();
    chk("b3_empty", 32'(b.empty), 1);
    chk("b3_level", 32'(b.level), 3);
    b.wr_data = 8'hDD;
    tick();
    b.wr_en = 0;
    chk("b4_empty", 32'(b.empty), 0);
    chk("b4_level", 32'(b.level), 4);
    b.rd_en = 1;
    tick();
    b.rd_en = 0;
    chk("b_valid", 32'(b.rd_valid), 1);
    chk("b_data", b.rd_data, 32'hDDCCBBAA);
    chk("b_empty", 32'(b.empty), 1);

    $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
    $finish;
  end
endmodule
